// File: rtl/ts_serial_rx.sv
// ts_serial_rx: serial MPEG-TS receiver.
// Oversamples the ts_clk/ts_valid/ts_sync/ts_d0 link in the clk domain and
// rebuilds bytes from it. Only complete PKT_LEN-byte packets are committed
// into a circular packet FIFO. Committed bytes are replayed on a
// valid/ready byte stream with m_sop/m_eop framing.
// Optional build macro: TS_SYNC_CHECK_EN. When it is defined, a packet whose
// first byte is not SYNC_BYTE is aborted and counted in err_cnt.
module ts_serial_rx #(
  parameter int          PKT_LEN   = 188,
  parameter int          FIFO_AW   = 9,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ts_clk,
  input  logic        ts_valid,
  input  logic        ts_sync,
  input  logic        ts_d0,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sop,
  output logic        m_eop,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam int                 BCW       = $clog2(PKT_LEN);
  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(PKT_LEN - 1);
  localparam logic [BCW-1:0]     BYTE_ONE  = BCW'(1);
  localparam logic [FIFO_AW:0]   DEPTH_P   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   PKT_LEN_P = (FIFO_AW + 1)'(PKT_LEN);
  localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

`ifdef TS_SYNC_CHECK_EN
  localparam bit SYNC_CHECK = 1'b1;
`else
  localparam bit SYNC_CHECK = 1'b0;
`endif

  typedef enum logic {HUNT, RECV} state_t;

  state_t state, state_next;

  // Synchroniser stages; the clock line has one extra stage for edge detect
  logic [2:0] clk_sync;
  logic [1:0] valid_sync;
  logic [1:0] sync_sync;
  logic [1:0] d0_sync;

  logic bit_event;
  logic s_valid;
  logic s_sync;
  logic s_d0;

  // Receive datapath
  logic [7:0]       shift_reg;
  logic [7:0]       new_byte;
  logic [2:0]       bit_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic [FIFO_AW:0] wr_work;
  logic [FIFO_AW:0] wr_commit;
  logic [FIFO_AW:0] rd;
  logic [FIFO_AW:0] free_work;
  logic [FIFO_AW:0] free_commit;
  logic             commit_pend;
  logic             sync_bad;

  // FSM action strobes
  logic do_start;
  logic do_drop;
  logic do_abort;
  logic do_shift;
  logic do_write;
  logic do_done;

  // Read side
  logic [7:0]       mem [DEPTH];
  logic             xfer;
  logic [FIFO_AW:0] rd_next;
  logic [BCW-1:0]   rd_cnt;
  logic [BCW-1:0]   rd_cnt_next;
  logic             have_data;

  // Bring the asynchronous link into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= '0;
      valid_sync <= '0;
      sync_sync  <= '0;
      d0_sync    <= '0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ts_clk};
      valid_sync <= {valid_sync[0], ts_valid};
      sync_sync  <= {sync_sync[0], ts_sync};
      d0_sync    <= {d0_sync[0], ts_d0};
    end
  end

  assign bit_event = clk_sync[1] & ~clk_sync[2];
  assign s_valid   = valid_sync[1];
  assign s_sync    = sync_sync[1];
  assign s_d0      = d0_sync[1];

  assign new_byte    = {shift_reg[6:0], s_d0};
  assign free_work   = DEPTH_P - (wr_work - rd);
  assign free_commit = DEPTH_P - (wr_commit - rd);
  assign sync_bad    = SYNC_CHECK && (new_byte != SYNC_BYTE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a start always lands in RECV, an abort or finish in HUNT
  always_comb begin
    state_next = state;
    if (do_start) begin
      state_next = RECV;
    end else if (do_abort || do_done) begin
      state_next = HUNT;
    end
  end

  // FSM outputs: decode the current bit event into datapath actions
  always_comb begin
    do_start = 1'b0;
    do_drop  = 1'b0;
    do_abort = 1'b0;
    do_shift = 1'b0;
    do_write = 1'b0;
    do_done  = 1'b0;
    case (state)
      HUNT: begin
        if (bit_event && s_valid && s_sync) begin
          if (free_work >= PKT_LEN_P) begin
            do_start = 1'b1;
          end else begin
            do_drop = 1'b1;
          end
        end
      end
      RECV: begin
        if (!s_valid) begin
          do_abort = 1'b1;
        end else if (bit_event && s_sync && (bit_cnt != 3'd0 || byte_cnt != '0)) begin
          do_abort = 1'b1;
          if (free_commit >= PKT_LEN_P) begin
            do_start = 1'b1;
          end else begin
            do_drop = 1'b1;
          end
        end else if (bit_event) begin
          do_shift = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == '0 && sync_bad) begin
              do_abort = 1'b1;
            end else begin
              do_write = 1'b1;
              if (byte_cnt == LAST_BYTE) begin
                do_done = 1'b1;
              end
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Receive datapath: bit/byte counters, write pointers and event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      wr_work     <= '0;
      wr_commit   <= '0;
      commit_pend <= 1'b0;
      drop_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      if (do_start) begin
        shift_reg <= {7'd0, s_d0};
        bit_cnt   <= 3'd1;
        byte_cnt  <= '0;
      end else if (do_shift) begin
        shift_reg <= new_byte;
        bit_cnt   <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
        if (do_write) begin
          byte_cnt <= byte_cnt + BYTE_ONE;
        end
      end

      if (do_abort) begin
        wr_work <= wr_commit;
      end else if (do_write) begin
        wr_work <= wr_work + PTR_ONE;
      end

      commit_pend <= do_done;
      if (commit_pend) begin
        wr_commit <= wr_work;
      end

      if (do_drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (do_abort && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  // Packet storage; the space check keeps writes clear of unread bytes
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_work[FIFO_AW-1:0]] <= new_byte;
    end
  end

  assign xfer        = m_valid & m_ready;
  assign rd_next     = xfer ? rd + PTR_ONE : rd;
  assign rd_cnt_next = xfer ? ((rd_cnt == LAST_BYTE) ? '0 : rd_cnt + BYTE_ONE) : rd_cnt;
  assign have_data   = (rd_next != wr_commit);

  // Registered first-word-fall-through read of the committed region
  always_ff @(posedge clk) begin
    if (reset) begin
      rd      <= '0;
      rd_cnt  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else begin
      rd      <= rd_next;
      rd_cnt  <= rd_cnt_next;
      m_valid <= have_data;
      m_sop   <= have_data && (rd_cnt_next == '0);
      m_eop   <= have_data && (rd_cnt_next == LAST_BYTE);
      if (have_data) begin
        m_data <= mem[rd_next[FIFO_AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_ts_serial_rx.sv
// tb_ts_serial_rx: scoreboard bench for ts_serial_rx.
// A packet-level model decides which packets are stored, dropped or aborted
// and queues the expected output bytes; a monitor pops and compares them.
module tb_ts_serial_rx;

  localparam int PKT_LEN = 188;
  localparam int FIFO_AW = 9;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        ts_clk;
  logic        ts_valid;
  logic        ts_sync;
  logic        ts_d0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sop;
  logic        m_eop;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         model_drop   = 0;
  int         model_err    = 0;
  int         out_count    = 0;
  int         ready_mode   = 1;
  logic [7:0] pkt [PKT_LEN];
  logic       hold_prev    = 1'b0;
  logic [9:0] hold_word    = '0;

  always #5 clk = ~clk;

  ts_serial_rx #(
    .PKT_LEN  (PKT_LEN),
    .FIFO_AW  (FIFO_AW),
    .SYNC_BYTE(8'h47)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ts_clk  (ts_clk),
    .ts_valid(ts_valid),
    .ts_sync (ts_sync),
    .ts_d0   (ts_d0),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sop   (m_sop),
    .m_eop   (m_eop),
    .drop_cnt(drop_cnt),
    .err_cnt (err_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit sync_ok(input logic [7:0] b);
`ifdef TS_SYNC_CHECK_EN
    return b == 8'h47;
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: pop the scoreboard on every transfer and check stall stability
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_output("stall_valid", {31'd0, m_valid}, 32'd1);
        check_output("stall_word", {22'd0, m_sop, m_eop, m_data}, {22'd0, hold_word});
      end
      if (m_valid && m_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no output", m_data);
        end else begin
          e = exp_q.pop_front();
          check_output("byte_data", {24'd0, m_data}, {24'd0, e.data});
          check_output("byte_sop_eop", {30'd0, m_sop, m_eop}, {30'd0, e.sop, e.eop});
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_word = {m_sop, m_eop, m_data};
    end
  end

  // Downstream ready pattern: 0 stall, 1 always, 2 toggle every 3 clk, 3 random
  initial begin
    int cnt;
    cnt = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: m_ready = 1'b0;
        1: m_ready = 1'b1;
        2: begin
          if (cnt % 3 == 0) m_ready = ~m_ready;
          cnt++;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic ts_byte(input logic [7:0] b, input bit first);
    for (int i = 7; i >= 0; i--) begin
      ts_d0   = b[i];
      ts_sync = first && (i == 7);
      #20 ts_clk = 1'b1;
      #20 ts_clk = 1'b0;
    end
    ts_sync = 1'b0;
  endtask

  task automatic fill_random(input logic [7:0] first);
    pkt[0] = first;
    for (int i = 1; i < PKT_LEN; i++) pkt[i] = 8'($urandom);
  endtask

  // Send the first n_bytes of pkt as one burst and update the packet model
  task automatic apply_stimulus(input int n_bytes, input bit keep_valid);
    bit accepted;
    accepted = (DEPTH - exp_q.size()) >= PKT_LEN;
    if (!accepted) model_drop++;
    if (!ts_valid) begin
      @(posedge clk);
      #2;
      ts_valid = 1'b1;
    end
    for (int i = 0; i < n_bytes; i++) ts_byte(pkt[i], i == 0);
    if (accepted) begin
      if (n_bytes == PKT_LEN && sync_ok(pkt[0])) begin
        for (int i = 0; i < PKT_LEN; i++)
          exp_q.push_back('{data: pkt[i], sop: (i == 0), eop: (i == PKT_LEN - 1)});
      end else begin
        model_err++;
      end
    end
    if (!keep_valid) begin
      ts_valid = 1'b0;
      #80;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    repeat (8) @(posedge clk);
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_output({name, "_drain"}, exp_q.size(), 0);
    check_output({name, "_idle"}, {31'd0, m_valid}, 32'd0);
    check_output({name, "_drop_cnt"}, {16'd0, drop_cnt}, model_drop);
    check_output({name, "_err_cnt"}, {16'd0, err_cnt}, model_err);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    bit keep;
    reset    = 1'b1;
    ts_clk   = 1'b0;
    ts_valid = 1'b0;
    ts_sync  = 1'b0;
    ts_d0    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("reset_word", {m_valid, m_sop, m_eop, m_data}, 32'd0);
    check_output("reset_cnts", {drop_cnt, err_cnt}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    $display("[TB] clean packet");
    ready_mode = 1;
    pkt[0] = 8'h47;
    for (int i = 1; i < PKT_LEN; i++) pkt[i] = 8'(i);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("clean");

    $display("[TB] overflow");
    ready_mode = 0;
    base = out_count;
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b1);
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b1);
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("ovf_drop_cnt", {16'd0, drop_cnt}, model_drop);
    check_output("ovf_stalled_head", {30'd0, m_valid, m_sop}, 32'd3);
    ready_mode = 1;
    wait_drain("overflow");
    check_output("ovf_bytes_out", out_count - base, 2 * PKT_LEN);

    $display("[TB] truncation");
    ready_mode = 3;
    fill_random(8'h47);
    apply_stimulus(100, 1'b0);
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("trunc");

    $display("[TB] resync");
    fill_random(8'h47);
    apply_stimulus(50, 1'b1);
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("resync");

    $display("[TB] sync byte check");
    ready_mode = 1;
    fill_random(8'h00);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("syncchk");

    $display("[TB] backpressure");
    ready_mode = 2;
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    ready_mode = 1;
    wait_drain("bp");

    $display("[TB] reset mid-packet");
    fill_random(8'h47);
    apply_stimulus(120, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("midrst_word", {m_valid, m_sop, m_eop, m_data}, 32'd0);
    check_output("midrst_cnts", {drop_cnt, err_cnt}, 32'd0);
    exp_q.delete();
    model_drop = 0;
    model_err  = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    ts_valid = 1'b0;
    #80;
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("after_rst");

    $display("[TB] random abort");
    ready_mode = 3;
    n    = $urandom_range(1, PKT_LEN - 1);
    keep = 1'($urandom_range(0, 1));
    fill_random(8'h47);
    apply_stimulus(n, keep);
    fill_random(8'h47);
    apply_stimulus(PKT_LEN, 1'b0);
    wait_drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ts_serial_rx.md
Name: ts_serial_rx

Overview:
Receives the serial MPEG-TS link driven by the rx glue: ts_clk, ts_valid, ts_sync and ts_d0, sent MSB first. Samples the link in the clk domain and deserialises it into bytes. Stores only complete PKT_LEN-byte packets in a commit-based packet FIFO, then replays them as a byte stream with valid/ready handshake and packet framing. Used on the loopback/test path and on the far end of the TS link, feeding the host packet sink.

Parameters:
PKT_LEN, 188, bytes per TS packet; 8 <= PKT_LEN <= 2^FIFO_AW.
FIFO_AW, 9, FIFO address width; depth is 2^FIFO_AW bytes (512).
SYNC_BYTE, 8'h47, expected first byte of every packet (used only with TS_SYNC_CHECK_EN).

Ports:
clk  input  1  system clock; must run at >= 4x ts_clk.
reset  input  1  synchronous, active-high reset.
ts_clk  input  1  serial TS bit clock, asynchronous to clk; data is captured on its rising edge.
ts_valid  input  1  high while a packet burst is in progress.
ts_sync  input  1  high on bit 7 of byte 0 of a packet.
ts_d0  input  1  serial data, MSB first.
m_data  output  8  output byte.
m_valid  output  1  m_data is valid.
m_ready  input  1  downstream accepts the byte.
m_sop  output  1  current byte is byte 0 of a packet.
m_eop  output  1  current byte is byte PKT_LEN-1 of a packet.
drop_cnt  output  16  packets dropped because the FIFO lacked space; saturates at 16'hFFFF.
err_cnt  output  16  packets aborted (truncated, resynced, or bad sync byte); saturates at 16'hFFFF.

Behaviour:
- Input sampling
  - All four ts_* inputs pass through a 2-flop synchroniser; ts_clk gets a 3rd flop for edge detect.
  - A "bit event" is a synchronised ts_clk rising edge. ts_d0, ts_sync and ts_valid are taken from the same synchroniser stage so they stay aligned with the event.
  - A bit event with synchronised ts_valid = 0 is ignored.
- FIFO pointers
  - Pointers are FIFO_AW+1 bits: wr_work, wr_commit, rd.
  - free = 2^FIFO_AW - (wr_work - rd), computed modulo 2^(FIFO_AW+1).
- FSM states: HUNT, RECV.
  - HUNT: on a bit event with ts_sync=1:
    - if free >= PKT_LEN, go to RECV; this bit is bit 7 of byte 0, so bit_cnt=1.
    - otherwise stay in HUNT and increment drop_cnt once; the rest of that packet is ignored because no further ts_sync occurs.
  - HUNT: bit events with ts_sync=0 are ignored.
  - RECV, each bit event: shift the bit in. On the 8th bit, write the byte at wr_work, increment wr_work and byte_cnt, clear bit_cnt.
  - RECV, packet complete: when byte PKT_LEN-1 is written, wr_commit <= wr_work in the next clk (wr_work value including that byte). Return to HUNT.
  - RECV, resync: a bit event with ts_sync=1 and bit_cnt/byte_cnt not both 0 aborts the packet:
    - wr_work <= wr_commit, err_cnt++.
    - The same event is re-evaluated as a HUNT start (space check applies) in the same cycle.
  - RECV, truncation: synchronised ts_valid falls before the packet completes.
    - wr_work <= wr_commit, err_cnt++, go to HUNT.
- Output side
  - Reads only from the committed region: m_valid = 1 when rd != wr_commit, first-word-fall-through from a registered read.
  - Latency: the first byte of a committed packet appears on m_valid within 2 clk of the wr_commit update.
  - A byte transfers when m_valid & m_ready; rd then increments.
  - While m_valid=1 and m_ready=0, m_data/m_sop/m_eop hold stable.
  - A read-side byte counter (0..PKT_LEN-1, wraps) drives m_sop (count 0) and m_eop (count PKT_LEN-1).
- Same-cycle events: a commit and a read can occur in the same clk; both take effect. An abort never disturbs bytes already committed.
- Reset
  - Pointers, counters, bit_cnt and byte_cnt are 0; FSM is HUNT.
  - m_valid, m_sop, m_eop, m_data, drop_cnt, err_cnt are 0.
  - Reset mid-packet discards the partial packet without incrementing err_cnt.

Optional Feature:
TS_SYNC_CHECK_EN
- Defined: when byte 0 completes in RECV and differs from SYNC_BYTE, abort the packet (wr_work <= wr_commit, err_cnt++, go to HUNT).
- Undefined: byte 0 is not checked; any value is accepted and committed.

Test Plan:
- Clean packet: one 188-byte burst, byte 0 = 0x47, bytes i = i; m_ready=1 -> 188 bytes out in order, m_sop on 0x47, m_eop on byte 187; drop_cnt=0, err_cnt=0.
- Overflow: m_ready=0, send 3 back-to-back packets (FIFO_AW=9) -> packets 1 and 2 stored, packet 3 dropped (free=136), drop_cnt=1. Then m_ready=1 -> exactly 376 bytes out.
- Truncation: ts_valid drops after 100 bytes, then a full good packet -> err_cnt=1, output is only the good packet with correct sop/eop.
- Resync: a new ts_sync arrives at byte 50 of a packet, then that new packet completes -> err_cnt=1, only the second packet is output.
- Sync check: packet with byte 0 = 0x00 -> with TS_SYNC_CHECK_EN: err_cnt=1, no output; without the macro: 188 bytes out, err_cnt=0.
- Backpressure/reset: toggle m_ready every 3 clk -> m_data stable while m_ready=0, all bytes in order. Assert reset at byte 120 of a burst -> all outputs 0, next packet received cleanly.
